// File: rtl/serial_pkg.sv
// Shared constants, the symbol type and a bit-pick helper for the 5-bit serializer.
// Optional build macro used by this slice: NRZI_EN (NRZI line coding on tx).
package serial_pkg;

    localparam int WORD_W   = 5;
    localparam int BITCNT_W = 3;

    typedef logic [WORD_W-1:0] symbol_t;

    localparam symbol_t IDLE_CODE = 5'b11111;

    // m1 sits in the MSB, so bit position idx of the symbol is sym[WORD_W-1-idx].
    function automatic logic bit_at(symbol_t sym, logic [BITCNT_W-1:0] idx);
        logic [BITCNT_W-1:0] pos;
        pos = BITCNT_W'(WORD_W - 1) - idx;
        return sym[pos];
    endfunction

endpackage

// File: rtl/serializador_5b_if.sv
// Word handshake and serial line bundle between codificador, serializer and line.
// Used by serializador_5b (slave side); NRZI_EN only changes how tx is coded.
interface serializador_5b_if;
    import serial_pkg::*;

    symbol_t m;
    logic    valid;
    logic    accept;
    logic    tx;
    logic    sym_start;
    logic    is_idle;

    modport master (
        output m,
        output valid,
        input  accept,
        input  tx,
        input  sym_start,
        input  is_idle
    );

    modport slave (
        input  m,
        input  valid,
        output accept,
        output tx,
        output sym_start,
        output is_idle
    );

endinterface

// File: rtl/serializador_5b_nrzi.sv
// NRZI line encoder: a 1 toggles the line level, a 0 holds it; level resets to 0.
// Only compiled when NRZI_EN is defined, so the plain NRZ build carries no NRZI logic.
`ifdef NRZI_EN
module nrzi_enc (
    input  logic clk,
    input  logic reset,
    input  logic bit_in,
    output logic line_out
);

    logic level_q;
    logic level_d;

    always_comb begin
        level_d = level_q ^ bit_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_d;
        end
    end

    assign line_out = level_q;

endmodule
`endif

// File: rtl/serializador_5b.sv
// Shifts 5-bit code words onto one serial line, m1 first, through a one-word buffer.
// Define NRZI_EN to NRZI-code tx; otherwise tx is the plain registered NRZ bit.
module serializador_5b
    import serial_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    serializador_5b_if.slave   bus
);

    logic [BITCNT_W-1:0] bitcnt_q, bitcnt_d;
    symbol_t             sreg_q, sreg_d;
    logic                sreg_is_idle_q, sreg_is_idle_d;
    symbol_t             buf_word_q, buf_word_d;
    logic                buf_valid_q, buf_valid_d;
    logic                sym_start_q, sym_start_d;
    logic                is_idle_q, is_idle_d;

    logic at_boundary;
    logic accept;
    logic cur_bit;
    logic tx_line;

    assign at_boundary = (bitcnt_q == BITCNT_W'(WORD_W - 1));
    assign accept      = !buf_valid_q || at_boundary;
    assign cur_bit     = bit_at(sreg_q, bitcnt_q);

    always_comb begin
        bitcnt_d       = bitcnt_q;
        sreg_d         = sreg_q;
        sreg_is_idle_d = sreg_is_idle_q;
        buf_word_d     = buf_word_q;
        buf_valid_d    = buf_valid_q;
        sym_start_d    = (bitcnt_q == '0);
        is_idle_d      = sreg_is_idle_q;

        if (at_boundary) begin
            bitcnt_d    = '0;
            buf_valid_d = 1'b0;
            if (buf_valid_q) begin
                sreg_d         = buf_word_q;
                sreg_is_idle_d = 1'b0;
            end else begin
                sreg_d         = IDLE_CODE;
                sreg_is_idle_d = 1'b1;
            end
        end else begin
            bitcnt_d = bitcnt_q + 1'b1;
        end

        // A new word may land in the buffer on the same edge the old one moves to sreg.
        if (bus.valid && accept) begin
            buf_word_d  = bus.m;
            buf_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bitcnt_q       <= '0;
            sreg_q         <= IDLE_CODE;
            sreg_is_idle_q <= 1'b1;
            buf_word_q     <= '0;
            buf_valid_q    <= 1'b0;
            sym_start_q    <= 1'b0;
            is_idle_q      <= 1'b1;
        end else begin
            bitcnt_q       <= bitcnt_d;
            sreg_q         <= sreg_d;
            sreg_is_idle_q <= sreg_is_idle_d;
            buf_word_q     <= buf_word_d;
            buf_valid_q    <= buf_valid_d;
            sym_start_q    <= sym_start_d;
            is_idle_q      <= is_idle_d;
        end
    end

`ifdef NRZI_EN
    nrzi_enc u_nrzi (
        .clk      (clk),
        .reset    (reset),
        .bit_in   (cur_bit),
        .line_out (tx_line)
    );
`else
    logic tx_q, tx_d;

    always_comb begin
        tx_d = cur_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_q <= 1'b0;
        end else begin
            tx_q <= tx_d;
        end
    end

    assign tx_line = tx_q;
`endif

    assign bus.accept    = accept;
    assign bus.tx        = tx_line;
    assign bus.sym_start = sym_start_q;
    assign bus.is_idle   = is_idle_q;

endmodule

// File: tb/tb_serializador_5b.sv
// Directed bench for serializador_5b: idle stream, single/back-to-back words,
// boundary accept, mid-symbol reset and NRZ/NRZI line coding (follows NRZI_EN).
module tb_serializador_5b;
    import serial_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic tb_level = 1'b0;
    symbol_t exp6;

    serializador_5b_if bus ();

    serializador_5b dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check1(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Line value is given directly (already coded).
    task automatic expect_line(input string tag, input logic line, input logic ss, input logic idle);
        @(posedge clk);
        #1;
        check1({tag, ".tx"}, bus.tx, line);
        check1({tag, ".sym_start"}, bus.sym_start, ss);
        check1({tag, ".is_idle"}, bus.is_idle, idle);
        $display("[TB] %s tx=%b sym_start=%b is_idle=%b", tag, bus.tx, bus.sym_start, bus.is_idle);
`ifdef NRZI_EN
        tb_level = line;
`endif
    endtask

    // Raw symbol bit; coded onto the line the way the build expects.
    task automatic expect_bit(input string tag, input logic b, input logic ss, input logic idle);
        logic line;
`ifdef NRZI_EN
        line = tb_level ^ b;
`else
        line = b;
`endif
        expect_line(tag, line, ss, idle);
    endtask

    task automatic expect_sym(input string tag, input symbol_t sym, input logic idle);
        for (int i = 0; i < WORD_W; i++)
            expect_bit($sformatf("%s[%0d]", tag, i), sym[WORD_W-1-i], (i == 0), idle);
    endtask

    task automatic check_accept(input string tag, input logic exp);
        #1;
        check1(tag, bus.accept, exp);
    endtask

    initial begin
        bus.m     = '0;
        bus.valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check1("rst.tx", bus.tx, 1'b0);
        check1("rst.sym_start", bus.sym_start, 1'b0);
        check1("rst.is_idle", bus.is_idle, 1'b1);
        check1("rst.accept", bus.accept, 1'b1);
        reset = 1'b0;

        // 1: idle stream
        expect_sym("t1.idle0", 5'b11111, 1'b1);
        expect_sym("t1.idle1", 5'b11111, 1'b1);
        expect_sym("t1.idle2", 5'b11111, 1'b1);

        // 2: single word offered at bitcnt=2
        expect_bit("t2.idle[0]", 1'b1, 1'b1, 1'b1);
        expect_bit("t2.idle[1]", 1'b1, 1'b0, 1'b1);
        bus.m = 5'b10101; bus.valid = 1'b1;
        check_accept("t2.accept_bc2", 1'b1);
        expect_bit("t2.idle[2]", 1'b1, 1'b0, 1'b1);
        bus.valid = 1'b0;
        check_accept("t2.accept_full", 1'b0);
        expect_bit("t2.idle[3]", 1'b1, 1'b0, 1'b1);
        expect_bit("t2.idle[4]", 1'b1, 1'b0, 1'b1);
        expect_sym("t2.word", 5'b10101, 1'b0);

        // 3: back-to-back words with valid held
        bus.m = 5'b00110; bus.valid = 1'b1;
        check_accept("t3.acc_w1", 1'b1);
        expect_bit("t3.idle[0]", 1'b1, 1'b1, 1'b1);
        bus.m = 5'b01001;
        check_accept("t3.wait_w2_b1", 1'b0);
        expect_bit("t3.idle[1]", 1'b1, 1'b0, 1'b1);
        check_accept("t3.wait_w2_b2", 1'b0);
        expect_bit("t3.idle[2]", 1'b1, 1'b0, 1'b1);
        expect_bit("t3.idle[3]", 1'b1, 1'b0, 1'b1);
        check_accept("t3.acc_w2_bound", 1'b1);
        expect_bit("t3.idle[4]", 1'b1, 1'b0, 1'b1);
        bus.m = 5'b10010;
        check_accept("t3.wait_w3", 1'b0);
        expect_bit("t3.w1[0]", 1'b0, 1'b1, 1'b0);
        expect_bit("t3.w1[1]", 1'b0, 1'b0, 1'b0);
        expect_bit("t3.w1[2]", 1'b1, 1'b0, 1'b0);
        expect_bit("t3.w1[3]", 1'b1, 1'b0, 1'b0);
        check_accept("t3.acc_w3_bound", 1'b1);
        expect_bit("t3.w1[4]", 1'b0, 1'b0, 1'b0);
        bus.valid = 1'b0;
        expect_sym("t3.w2", 5'b01001, 1'b0);
        expect_sym("t3.w3", 5'b10010, 1'b0);

        // 4: valid rises at a boundary with the buffer empty
        expect_bit("t4.idle[0]", 1'b1, 1'b1, 1'b1);
        expect_bit("t4.idle[1]", 1'b1, 1'b0, 1'b1);
        expect_bit("t4.idle[2]", 1'b1, 1'b0, 1'b1);
        expect_bit("t4.idle[3]", 1'b1, 1'b0, 1'b1);
        bus.m = 5'b01101; bus.valid = 1'b1;
        check_accept("t4.accept_bound", 1'b1);
        expect_bit("t4.idle[4]", 1'b1, 1'b0, 1'b1);
        bus.valid = 1'b0;
        expect_sym("t4.idle_first", 5'b11111, 1'b1);
        expect_sym("t4.word", 5'b01101, 1'b0);

        // 5: reset in the middle of symbol 01110
        bus.m = 5'b01110; bus.valid = 1'b1;
        expect_bit("t5.idle[0]", 1'b1, 1'b1, 1'b1);
        bus.valid = 1'b0;
        expect_bit("t5.idle[1]", 1'b1, 1'b0, 1'b1);
        expect_bit("t5.idle[2]", 1'b1, 1'b0, 1'b1);
        expect_bit("t5.idle[3]", 1'b1, 1'b0, 1'b1);
        expect_bit("t5.idle[4]", 1'b1, 1'b0, 1'b1);
        expect_bit("t5.w[0]", 1'b0, 1'b1, 1'b0);
        expect_bit("t5.w[1]", 1'b1, 1'b0, 1'b0);
        expect_bit("t5.w[2]", 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        tb_level = 1'b0;
        #1;
        check1("t5.async.tx", bus.tx, 1'b0);
        check1("t5.async.sym_start", bus.sym_start, 1'b0);
        check1("t5.async.is_idle", bus.is_idle, 1'b1);
        check1("t5.async.accept", bus.accept, 1'b1);
        @(posedge clk);
        #1;
        check1("t5.held.tx", bus.tx, 1'b0);
        reset = 1'b0;
        expect_sym("t5.restart", 5'b11111, 1'b1);

        // 6: line coding of 10110 starting from level 0
        bus.m = 5'b10110; bus.valid = 1'b1;
        check_accept("t6.accept", 1'b1);
        expect_bit("t6.idle[0]", 1'b1, 1'b1, 1'b1);
        bus.valid = 1'b0;
        expect_bit("t6.idle[1]", 1'b1, 1'b0, 1'b1);
        expect_bit("t6.idle[2]", 1'b1, 1'b0, 1'b1);
        expect_bit("t6.idle[3]", 1'b1, 1'b0, 1'b1);
        expect_bit("t6.idle[4]", 1'b1, 1'b0, 1'b1);
`ifdef NRZI_EN
        exp6 = 5'b11011;
`else
        exp6 = 5'b10110;
`endif
        for (int i = 0; i < WORD_W; i++)
            expect_line($sformatf("t6.line[%0d]", i), exp6[WORD_W-1-i], (i == 0), 1'b0);
        expect_sym("t6.idle_after", 5'b11111, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
